// File: rtl/systolic_result_drain_pkg.sv
// systolic_result_drain_pkg: shared Q1.15 constants and drain FSM encoding
package systolic_result_drain_pkg;
  localparam int DATA_BITS_DEF = 16;
  localparam logic [15:0] Q115_MAX = 16'h7fff;
  localparam logic [15:0] Q115_MIN = 16'h8000;
  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;
endpackage

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots a PE column's results and streams them out over valid/ready
module systolic_result_drain
  import systolic_result_drain_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int NUM_PE = 4,
  parameter int IDX_BITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          drain_start,
  input  logic [NUM_PE*DATA_BITS-1:0]   acc_in,
  output logic                          clear_acc,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_BITS-1:0]          out_data,
  output logic [IDX_BITS-1:0]           out_index,
  output logic                          out_last,
  output logic                          done,
  output logic                          overrun
);
  state_t state;
  logic [IDX_BITS-1:0] idx;
  logic [DATA_BITS-1:0] cap_buf [NUM_PE];
  logic fire;
  assign busy = state == STREAM;
  assign out_valid = busy;
  assign out_index = idx;
  assign out_data = cap_buf[idx];
  assign out_last = busy && idx == IDX_BITS'(NUM_PE - 1);
  assign fire = out_valid && out_ready;
  // buffer is only loaded from IDLE, so a late start never disturbs an in-flight drain
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cap_buf <= '{default: '0};
      clear_acc <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      clear_acc <= drain_start && !busy;
      done <= fire && out_last;
      if (drain_start && busy) overrun <= 1'b1;
      if (!busy && drain_start) begin
        for (int i = 0; i < NUM_PE; i++) cap_buf[i] <= acc_in[i*DATA_BITS +: DATA_BITS];
        state <= STREAM;
      end else if (fire) begin
        idx <= out_last ? '0 : idx + 1'b1;
        if (out_last) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: directed scoreboard bench for the result drain
module tb_systolic_result_drain;
  import systolic_result_drain_pkg::*;
  typedef struct packed {logic [15:0] d; logic [1:0] i; logic l;} beat_t;
  logic clk = 0, reset = 1, drain_start = 0, out_ready = 1;
  logic [63:0] acc_in = '0;
  logic clear_acc, busy, out_valid, out_last, done, overrun;
  logic [15:0] out_data;
  logic [1:0] out_index;
  beat_t q[$];
  int n_assert = 0, n_fail = 0;
  int n_clear = 0, n_done = 0, n_beats = 0, n_busy = 0, cyc_cnt = 0;
  logic pend_done = 0, prev_stall = 0;
  logic [15:0] prev_data;
  logic [1:0] prev_idx;

  systolic_result_drain dut (
    .clk(clk), .reset(reset), .drain_start(drain_start), .acc_in(acc_in),
    .clear_acc(clear_acc), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: monitor the current cycle, then advance to #1 after the next edge
  task automatic cyc();
    beat_t b;
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
      chk("stall_index", 32'(out_index), 32'(prev_idx));
    end
    if (pend_done) chk("done_after_last", 32'(done), 1);
    n_clear += int'(clear_acc);
    n_done += int'(done);
    n_busy += int'(busy);
    if (out_valid && out_ready) begin
      n_beats++;
      if (q.size() == 0) chk("unexpected_beat", 32'(out_index), 32'hffff_ffff);
      else begin
        b = q.pop_front();
        chk("beat_data", 32'(out_data), 32'(b.d));
        chk("beat_index", 32'(out_index), 32'(b.i));
        chk("beat_last", 32'(out_last), 32'(b.l));
      end
    end
    pend_done = out_valid && out_ready && out_last;
    prev_stall = out_valid && !out_ready;
    prev_data = out_data;
    prev_idx = out_index;
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic start_drain(input logic [15:0] l0, l1, l2, l3);
    acc_in = {l3, l2, l1, l0};
    q.push_back('{d: l0, i: 2'd0, l: 1'b0});
    q.push_back('{d: l1, i: 2'd1, l: 1'b0});
    q.push_back('{d: l2, i: 2'd2, l: 1'b0});
    q.push_back('{d: l3, i: 2'd3, l: 1'b1});
    drain_start = 1;
    cyc();
    drain_start = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) cyc();
    chk("wait_done", 32'(done), 1);
  endtask

  task automatic zero_counts();
    n_clear = 0; n_done = 0; n_beats = 0; n_busy = 0;
  endtask

  initial begin
    int pat [7];
    int c0;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    repeat (2) cyc();
    chk("rst_clear", 32'(clear_acc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_index", 32'(out_index), 0);
    reset = 0;
    cyc();
    chk("post_rst_clear", 32'(clear_acc), 0);

    // basic drain with boundary Q1.15 values
    zero_counts();
    start_drain(Q115_MAX, Q115_MIN, 16'h0001, 16'h1234);
    chk("basic_clear", 32'(clear_acc), 1);
    chk("basic_first_valid", 32'(out_valid), 1);
    repeat (6) cyc();
    chk("basic_busy_cycles", 32'(n_busy), 4);
    chk("basic_beats", 32'(n_beats), 4);
    chk("basic_clear_count", 32'(n_clear), 1);
    chk("basic_done_count", 32'(n_done), 1);
    chk("basic_q_empty", 32'(q.size()), 0);
    chk("basic_overrun", 32'(overrun), 0);

    // backpressure
    zero_counts();
    start_drain(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0];
      cyc();
    end
    out_ready = 1;
    repeat (3) cyc();
    chk("bp_beats", 32'(n_beats), 4);
    chk("bp_q_empty", 32'(q.size()), 0);
    chk("bp_done_count", 32'(n_done), 1);

    // acc_in changes after the snapshot
    start_drain(16'h0a0a, 16'hb0b0, 16'h0c0c, 16'hd0d0);
    acc_in = {4{16'hffff}};
    repeat (6) cyc();
    chk("acc_q_empty", 32'(q.size()), 0);

    // overrun: start at idx 1, then coincident with final transfer
    zero_counts();
    start_drain(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    cyc();
    chk("ovr_idx1", 32'(out_index), 1);
    drain_start = 1;
    acc_in = {4{16'h5555}};
    cyc();
    drain_start = 0;
    chk("ovr_set", 32'(overrun), 1);
    chk("ovr_no_clear", 32'(clear_acc), 0);
    cyc();
    chk("ovr_idx3", 32'(out_index), 3);
    drain_start = 1;
    cyc();
    drain_start = 0;
    chk("ovr_done_cycle", 32'(done), 1);
    chk("ovr_no_clear2", 32'(clear_acc), 0);
    start_drain(16'h0aaa, 16'h0bbb, 16'h0ccc, 16'h0ddd);
    chk("ovr_restart_clear", 32'(clear_acc), 1);
    chk("ovr_sticky", 32'(overrun), 1);
    repeat (6) cyc();
    chk("ovr_clear_count", 32'(n_clear), 2);
    chk("ovr_q_empty", 32'(q.size()), 0);

    // reset mid-stream at idx 2
    start_drain(16'h1001, 16'h2002, 16'h3003, 16'h4004);
    cyc();
    cyc();
    chk("mid_idx2", 32'(out_index), 2);
    reset = 1;
    cyc();
    chk("mid_valid", 32'(out_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_overrun", 32'(overrun), 0);
    chk("mid_done", 32'(done), 0);
    chk("mid_clear", 32'(clear_acc), 0);
    reset = 0;
    pend_done = 0;
    q.delete();
    cyc();
    chk("mid_post_clear", 32'(clear_acc), 0);
    chk("mid_post_done", 32'(done), 0);

    // back-to-back drains started in each done cycle
    zero_counts();
    start_drain(16'h000a, 16'h000b, 16'h000c, 16'h000d);
    c0 = cyc_cnt;
    wait_done();
    start_drain(16'h00a0, 16'h00b0, 16'h00c0, 16'h00d0);
    wait_done();
    start_drain(16'h0a00, 16'h0b00, 16'h0c00, 16'h0d00);
    wait_done();
    chk("b2b_span", 32'(cyc_cnt - c0), 14);
    repeat (3) cyc();
    chk("b2b_beats", 32'(n_beats), 12);
    chk("b2b_busy", 32'(n_busy), 12);
    chk("b2b_clear", 32'(n_clear), 3);
    chk("b2b_done", 32'(n_done), 3);
    chk("b2b_q_empty", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
